// File: rtl/uart_prog_loader_pkg.sv
// Shared types for the serial program loader: frame FSM and UART bit-layer state encodings.
package uart_prog_loader_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } frm_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// UART receive core: 2-FF synchroniser, glitch-checked start bit, LSB-first 8N1 byte capture.
module uart_rx_core
   import uart_prog_loader_pkg::*;
#(
   parameter int CLK_DIV = 347
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_vld,
   output logic [7:0] byte_data,
   output logic       frm_err
);

   localparam int CW = $clog2(CLK_DIV);

   logic            rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e       st_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            stop_smp;

   // Strobes fire in the stop-sample cycle so the frame FSM reacts on the next edge.
   assign stop_smp  = (st_q == RX_STOP) && (cnt_q == CW'(CLK_DIV - 1));
   assign byte_vld  = stop_smp && rx_sync_q;
   assign frm_err   = stop_smp && !rx_sync_q;
   assign byte_data = shift_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         st_q      <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         case (st_q)
            RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
               st_q  <= RX_START;
               cnt_q <= '0;
            end
            RX_START: if (cnt_q == CW'(CLK_DIV / 2 - 1)) begin
               cnt_q <= '0;
               bit_q <= '0;
               st_q  <= rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            RX_DATA: if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_q   <= '0;
               shift_q <= {rx_sync_q, shift_q[7:1]};
               bit_q   <= bit_q + 1'b1;
               if (bit_q == 3'd7) st_q <= RX_STOP;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            RX_STOP: if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_q <= '0;
               st_q  <= RX_IDLE;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
            default: st_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: SYNC/LEN/DATA/CSUM frames from the UART into instr_mem, with CPU hold.
module uart_prog_loader
   import uart_prog_loader_pkg::*;
#(
   parameter int         CLK_DIV   = 347,
   parameter int         TIMEOUT   = 65535,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] instr_mem_addr,
   output logic [7:0] instr_mem_data,
   output logic       instr_mem_en,
   output logic       hold_cpu,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic          byte_vld, frm_err;
   logic [7:0]    byte_data;

   frm_state_e    st_q;
   logic [7:0]    addr_q, sum_q, mem_addr_q, mem_data_q;
   logic [8:0]    cnt_q;
   logic [TW-1:0] tmo_q;
   logic          en_q, hold_q, busy_q, done_q, err_q;

   uart_rx_core #(.CLK_DIV(CLK_DIV)) u_rx (
      .clock     (clock),
      .reset     (reset),
      .rx        (rx),
      .byte_vld  (byte_vld),
      .byte_data (byte_data),
      .frm_err   (frm_err)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st_q       <= S_IDLE;
         addr_q     <= '0;
         sum_q      <= '0;
         cnt_q      <= '0;
         tmo_q      <= '0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         en_q       <= 1'b0;
         hold_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         en_q <= 1'b0;
         case (st_q)
            S_IDLE: if (byte_vld && byte_data == SYNC_BYTE) begin
               st_q   <= S_LEN;
               hold_q <= 1'b1;
               busy_q <= 1'b1;
               done_q <= 1'b0;
               err_q  <= 1'b0;
               addr_q <= '0;
               tmo_q  <= '0;
            end
            // SYNC_BYTE values here are ordinary payload; no mid-frame resync.
            S_LEN, S_DATA, S_CSUM: begin
               if (frm_err) begin
                  st_q <= S_ERR;
               end else if (byte_vld) begin
                  tmo_q <= '0;
                  if (st_q == S_LEN) begin
                     cnt_q <= (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
                     sum_q <= '0;
                     st_q  <= S_DATA;
                  end else if (st_q == S_DATA) begin
                     mem_data_q <= byte_data;
                     mem_addr_q <= addr_q;
                     en_q       <= 1'b1;
                     addr_q     <= addr_q + 1'b1;
                     sum_q      <= sum_q + byte_data;
                     cnt_q      <= cnt_q - 1'b1;
                     if (cnt_q == 9'd1) st_q <= S_CSUM;
                  end else begin
                     st_q <= (byte_data == sum_q) ? S_DONE : S_ERR;
                  end
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  st_q <= S_ERR;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               hold_q <= 1'b0;
               st_q   <= S_IDLE;
            end
            S_ERR: begin
               err_q  <= 1'b1;
               busy_q <= 1'b0;
               st_q   <= S_IDLE;
            end
            default: st_q <= S_IDLE;
         endcase
      end
   end

   assign instr_mem_addr = mem_addr_q;
   assign instr_mem_data = mem_data_q;
   assign instr_mem_en   = en_q;
   assign hold_cpu       = hold_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed + randomized frames against a byte-level model of memory contents and status flags.
module tb_uart_prog_loader;

   localparam int CLK_DIV = 4;
   localparam int TIMEOUT = 64;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic [7:0] instr_mem_addr, instr_mem_data;
   logic       instr_mem_en, hold_cpu, busy, done, err;

   uart_prog_loader #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
      .clock          (clock),
      .reset          (reset),
      .rx             (rx),
      .instr_mem_addr (instr_mem_addr),
      .instr_mem_data (instr_mem_data),
      .instr_mem_en   (instr_mem_en),
      .hold_cpu       (hold_cpu),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mem     [256];
   logic [7:0] exp_mem [256];
   logic [7:0] fd      [256];
   int         en_cnt  = 0;
   int         exp_en  = 0;
   logic       exp_done = 0, exp_err = 0, exp_hold = 0;

   // Observed memory image built from the write strobe.
   always @(negedge clock) begin
      if (instr_mem_en) begin
         mem[instr_mem_addr] = instr_mem_data;
         en_cnt++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      rx = 1'b0;
      repeat (CLK_DIV) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CLK_DIV) @(negedge clock);
      end
      rx = stop;
      repeat (CLK_DIV) @(negedge clock);
      rx = 1'b1;
      repeat (CLK_DIV) @(negedge clock);
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_err"},  err,  exp_err);
      chk({tag, "_hold"}, hold_cpu, exp_hold);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_en_cnt"}, en_cnt, exp_en);
   endtask

   task automatic check_mem(input string tag, input int len);
      for (int i = 0; i < len; i++)
         chk($sformatf("%s_mem%0d", tag, i), mem[i], exp_mem[i]);
   endtask

   // Model: a frame writes fd[0..len-1] at addresses 0.., then checksum decides done vs err.
   task automatic send_frame(input string tag, input int len, input logic bad);
      logic [7:0] sum;
      logic [8:0] l9;
      sum = 8'd0;
      l9  = 9'(len);
      send_byte(8'hA5);
      send_byte(l9[7:0]);
      for (int i = 0; i < len; i++) begin
         send_byte(fd[i]);
         sum = sum + fd[i];
         exp_mem[i % 256] = fd[i];
      end
      send_byte(bad ? (sum ^ 8'h5A) : sum);
      repeat (6) @(negedge clock);
      exp_en   += len;
      exp_done = !bad;
      exp_err  = bad;
      exp_hold = bad;
      check_status(tag);
      check_mem(tag, len);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'h00;
         exp_mem[i] = 8'h00;
      end
      repeat (3) @(negedge clock);
      chk("rst_addr", instr_mem_addr, 8'h00);
      chk("rst_data", instr_mem_data, 8'h00);
      chk("rst_en", instr_mem_en, 1'b0);
      chk("rst_hold", hold_cpu, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      // Basic good frame with mid-frame hold/busy observation.
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h11);
      chk("f1_hold_mid", hold_cpu, 1'b1);
      chk("f1_busy_mid", busy, 1'b1);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h66);
      repeat (6) @(negedge clock);
      exp_mem[0] = 8'h11; exp_mem[1] = 8'h22; exp_mem[2] = 8'h33;
      exp_en += 3; exp_done = 1; exp_err = 0; exp_hold = 0;
      check_status("f1");
      check_mem("f1", 3);

      // Bad checksum keeps the CPU held.
      fd[0] = 8'h10; fd[1] = 8'h20;
      send_frame("bad", 2, 1'b1);

      // Noise before sync is ignored; A5 inside the frame is data.
      send_byte(8'h00);
      send_byte(8'hFF);
      fd[0] = 8'hA5; fd[1] = 8'h3C; fd[2] = 8'h01;
      send_frame("sync_data", 3, 1'b0);

      // One-cycle glitch on idle line.
      rx = 1'b0;
      @(negedge clock);
      rx = 1'b1;
      repeat (20) @(negedge clock);
      chk("glitch_busy", busy, 1'b0);
      chk("glitch_en_cnt", en_cnt, exp_en);
      chk("glitch_done", done, exp_done);

      // Randomized frames.
      for (int f = 0; f < 5; f++) begin
         int len;
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) fd[i] = 8'($urandom);
         send_frame($sformatf("rnd%0d", f), len, 1'($urandom_range(0, 1)));
      end

      // Full 256-byte frame via LEN=0.
      for (int i = 0; i < 256; i++) fd[i] = 8'(i);
      send_frame("len256", 256, 1'b0);

      // Stop bit forced low mid-DATA.
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h44);
      send_byte(8'h55, 1'b0);
      repeat (6) @(negedge clock);
      exp_mem[0] = 8'h44; exp_en += 1;
      exp_done = 0; exp_err = 1; exp_hold = 1;
      check_status("frmerr");
      check_mem("frmerr", 1);

      // Stall after LEN.
      send_byte(8'hA5);
      send_byte(8'h03);
      chk("stall_busy_mid", busy, 1'b1);
      chk("stall_err_mid", err, 1'b0);
      repeat (TIMEOUT + 16) @(negedge clock);
      exp_done = 0; exp_err = 1; exp_hold = 1;
      check_status("stall");

      // Good frame after an error releases the CPU.
      fd[0] = 8'h7E;
      send_frame("recover", 1, 1'b0);

      // Reset mid-DATA.
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h99);
      reset = 1'b1;
      #1;
      chk("mrst_addr", instr_mem_addr, 8'h00);
      chk("mrst_data", instr_mem_data, 8'h00);
      chk("mrst_en", instr_mem_en, 1'b0);
      chk("mrst_hold", hold_cpu, 1'b0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_done", done, 1'b0);
      chk("mrst_err", err, 1'b0);
      exp_mem[0] = 8'h99; exp_en += 1;
      check_mem("mrst", 1);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      fd[0] = 8'hC3; fd[1] = 8'h5A;
      send_frame("post_rst", 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
